tm1638_frame_sender: RTL and testbench

TM1638_FRAME_SENDER -- requirements
Module: tm1638_frame_sender

---
 rtl/tm1638_frame_sender.sv | 145 ++++++++++++++
 tb/tb_tm1638_frame_sender.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_sender.sv
// Sends one full TM1638 display frame (mode, 16 data bytes, display control)
// over the three-wire STB/CLK/DIO interface, LSB first.
module tm1638_frame_sender #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] seg_data,
  input  logic [7:0]  led_data,
  input  logic [2:0]  brightness,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);
  typedef enum logic [2:0] {IDLE, SETUP, BIT_LOW, BIT_HIGH, GAP, DONE} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state;
  logic [8:0]  cnt;
  logic [2:0]  bit_idx;
  logic [4:0]  byte_idx;
  logic [1:0]  txn;
  logic [63:0] seg_q;
  logic [7:0]  led_q;
  logic [2:0]  bri_q;

  // Byte k of transaction t; in T2, k=0 is the address command and data follows.
  function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [4:0] k,
                                            input logic [63:0] seg, input logic [7:0] led,
                                            input logic [2:0] bri);
    logic [3:0] d;
    d = 4'(k - 5'd1);
    if (t == 2'd0)      return 8'h40;
    else if (t == 2'd2) return {5'b10001, bri};
    else if (k == 5'd0) return 8'hC0;
    else if (d[0])      return {7'b0, led[d[3:1]]};
    else                return seg[{d[3:1], 3'b000} +: 8];
  endfunction

  logic       last_byte;
  logic [2:0] nxt_bit;
  logic [4:0] nxt_byte;
  logic [7:0] cur_val, nxt_val;
  logic       cur_bit, nxt_dio;

  assign last_byte = (byte_idx == ((txn == 2'd1) ? 5'd16 : 5'd0));
  assign nxt_bit   = bit_idx + 3'd1;
  assign nxt_byte  = (bit_idx == 3'd7) ? byte_idx + 5'd1 : byte_idx;
  assign cur_val   = frame_byte(txn, byte_idx, seg_q, led_q, bri_q);
  assign nxt_val   = frame_byte(txn, nxt_byte, seg_q, led_q, bri_q);
  assign cur_bit   = cur_val[bit_idx];
  assign nxt_dio   = nxt_val[nxt_bit];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      txn      <= '0;
      seg_q    <= '0;
      led_q    <= '0;
      bri_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tm_stb   <= 1'b1;
      tm_clk   <= 1'b1;
      tm_dio   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          // DONE also accepts start so back-to-back frames have no idle cycle
          if (start) begin
            seg_q    <= seg_data;
            led_q    <= led_data;
            bri_q    <= brightness;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            txn      <= '0;
            busy     <= 1'b1;
            tm_stb   <= 1'b0;
            state    <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            tm_clk <= 1'b0;
            tm_dio <= cur_bit;
            state  <= BIT_LOW;
          end else cnt <= cnt + 9'd1;
        end
        BIT_LOW: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            tm_clk <= 1'b1;
            state  <= BIT_HIGH;
          end else cnt <= cnt + 9'd1;
        end
        BIT_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7 && last_byte) begin
              bit_idx  <= '0;
              byte_idx <= '0;
              tm_stb   <= 1'b1;
              tm_dio   <= 1'b1;
              state    <= GAP;
            end else begin
              bit_idx  <= nxt_bit;
              byte_idx <= nxt_byte;
              tm_clk   <= 1'b0;
              tm_dio   <= nxt_dio;
              state    <= BIT_LOW;
            end
          end else cnt <= cnt + 9'd1;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (txn == 2'd2) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              txn    <= txn + 2'd1;
              tm_stb <= 1'b0;
              state  <= SETUP;
            end
          end else cnt <= cnt + 9'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm1638_frame_sender.sv
// Scoreboard bench: two DUTs (CLK_DIV 4 and 1), a wire-level decoder checks
// bytes, transaction lengths, bit timing and frame length against a frame model.
module tb_tm1638_frame_sender;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [2];
  logic [63:0] seg_s   [2];
  logic [7:0]  led_s   [2];
  logic [2:0]  br_s    [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        stb_w   [2];
  logic        ck_w    [2];
  logic        dio_w   [2];
  int          divs    [2] = '{D0, D1};

  always #5 clk = ~clk;

  tm1638_frame_sender #(.CLK_DIV(D0)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .seg_data(seg_s[0]),
    .led_data(led_s[0]), .brightness(br_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .tm_stb(stb_w[0]), .tm_clk(ck_w[0]), .tm_dio(dio_w[0]));

  tm1638_frame_sender #(.CLK_DIV(D1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .seg_data(seg_s[1]),
    .led_data(led_s[1]), .brightness(br_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .tm_stb(stb_w[1]), .tm_clk(ck_w[1]), .tm_dio(dio_w[1]));

  logic [7:0] exp_bytes [$];
  int         exp_lens  [$];
  int         exp_frames[$];
  int         errs = 0;
  int         chks = 0;

  function automatic void check(input string name, input longint act, input longint req);
    chks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name, input longint act);
    chks++;
    errs++;
    $display("FAIL %s: got 0x%0h, nothing expected", name, act);
  endfunction

  // Reference frame: mode cmd, address cmd + interleaved seg/led bytes, display cmd.
  task automatic model_frame(input int d, input logic [63:0] seg, input logic [7:0] led,
                             input logic [2:0] br);
    exp_bytes.push_back(8'h40);
    exp_lens.push_back(1);
    exp_bytes.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_bytes.push_back(seg[8*i +: 8]);
      exp_bytes.push_back(led[i] ? 8'h01 : 8'h00);
    end
    exp_lens.push_back(17);
    exp_bytes.push_back(8'h88 | {5'b0, br});
    exp_lens.push_back(1);
    exp_frames.push_back(3 * (3 * d) + 19 * 16 * d + 1);
  endtask

  // Wire-level decoder / monitor
  int         in_txn[2], bits[2], nbytes[2], plen[2], gap[2], bcnt[2];
  logic [7:0] acc[2];
  logic       pbad[2], dbad[2], ibad[2], hid[2], pstb[2], pck[2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        in_txn[g] = 0; gap[g] = 1000; bcnt[g] = 0;
        pstb[g] = 1'b1; pck[g] = 1'b1; ibad[g] = 1'b0;
      end else begin
        if (stb_w[g] && !dio_w[g]) ibad[g] = 1'b1;
        if (pstb[g] && !stb_w[g]) begin
          check("stb_gap_min", (gap[g] >= 2 * divs[g]) ? 1 : 0, 1);
          in_txn[g] = 1; bits[g] = 0; nbytes[g] = 0; plen[g] = 1;
          pbad[g] = 1'b0; dbad[g] = 1'b0; hid[g] = dio_w[g]; acc[g] = 8'h00;
        end else if (!stb_w[g] && in_txn[g] != 0) begin
          if (ck_w[g] != pck[g]) begin
            if (plen[g] != divs[g]) pbad[g] = 1'b1;
            plen[g] = 1;
            if (ck_w[g]) begin
              acc[g] = {dio_w[g], acc[g][7:1]};
              hid[g] = dio_w[g];
              bits[g]++;
              if (bits[g] == 8) begin
                bits[g] = 0;
                nbytes[g]++;
                if (exp_bytes.size() == 0) fail_now("unexpected_byte", acc[g]);
                else check("byte", acc[g], exp_bytes.pop_front());
              end
            end
          end else begin
            plen[g]++;
            if (ck_w[g] && dio_w[g] != hid[g]) dbad[g] = 1'b1;
          end
        end else if (!pstb[g] && stb_w[g] && in_txn[g] != 0) begin
          if (plen[g] != divs[g] || bits[g] != 0) pbad[g] = 1'b1;
          in_txn[g] = 0;
          if (exp_lens.size() == 0) fail_now("unexpected_txn", nbytes[g]);
          else check("txn_bytes", nbytes[g], exp_lens.pop_front());
          check("phase_timing_bad", pbad[g], 0);
          check("dio_changed_clk_high", dbad[g], 0);
        end
        if (stb_w[g]) gap[g] = pstb[g] ? gap[g] + 1 : 1;
        if (busy_w[g]) bcnt[g]++;
        if (done_w[g]) begin
          check("busy_low_at_done", busy_w[g], 0);
          if (exp_frames.size() == 0) fail_now("unexpected_done", bcnt[g] + 1);
          else check("frame_len", bcnt[g] + 1, exp_frames.pop_front());
          check("dio_low_while_stb_high", ibad[g], 0);
          ibad[g] = 1'b0;
          bcnt[g] = 0;
        end
        pstb[g] = stb_w[g];
        pck[g]  = ck_w[g];
      end
    end
  end

  // Caller must be just past a negedge; start is held for exactly one rising edge.
  task automatic send(input int g, input logic [63:0] seg, input logic [7:0] led,
                      input logic [2:0] br);
    seg_s[g] = seg; led_s[g] = led; br_s[g] = br; start_s[g] = 1'b1;
    model_frame(divs[g], seg, led, br);
    @(negedge clk);
    start_s[g] = 1'b0;
    check("busy_after_accept", busy_w[g], 1);
  endtask

  task automatic wait_done(input int g, input bit scramble);
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (done_w[g]) break;
      if (scramble) begin
        seg_s[g] = {$urandom, $urandom};
        led_s[g] = 8'($urandom);
        br_s[g]  = 3'($urandom);
      end
    end
    if (n == 4000) fail_now("done_timeout", n);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; seg_s[g] = '0; led_s[g] = '0; br_s[g] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_stb", stb_w[g], 1);
      check("rst_clk", ck_w[g], 1);
      check("rst_dio", dio_w[g], 1);
      check("rst_busy", busy_w[g], 0);
      check("rst_done", done_w[g], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 64'h0706050403020100, 8'hA5, 3'd7);
    wait_done(0, 1'b0);
    @(negedge clk);
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    wait_done(0, 1'b0);

    // inputs scrambled every cycle while the frame runs
    @(negedge clk);
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    wait_done(0, 1'b1);

    // start while busy must be ignored
    @(negedge clk);
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    repeat (300) @(negedge clk);
    seg_s[0] = '1; led_s[0] = 8'hFF; br_s[0] = 3'd3; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("busy_held", busy_w[0], 1);
    wait_done(0, 1'b0);

    // start in the done cycle
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    wait_done(0, 1'b0);

    // reset mid-T2
    @(negedge clk);
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    repeat (400) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stb", stb_w[0], 1);
    check("midrst_clk", ck_w[0], 1);
    check("midrst_dio", dio_w[0], 1);
    check("midrst_busy", busy_w[0], 0);
    check("midrst_done", done_w[0], 0);
    exp_bytes.delete(); exp_lens.delete(); exp_frames.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(0, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    wait_done(0, 1'b0);

    // CLK_DIV=1 instance
    @(negedge clk);
    send(1, {$urandom, $urandom}, 8'($urandom), 3'd0);
    wait_done(1, 1'b0);
    @(negedge clk);
    send(1, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    wait_done(1, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_bytes.size() + exp_lens.size() + exp_frames.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
